// File: rtl/cmd_regfile.sv
// Command-driven register file: one read/write per cmd handshake, buffered response on rsp channel.
// Optional write lock on mem[0] bit 0 enabled by defining CMD_REGFILE_WLOCK_EN.
//
// state | meaning
// IDLE  | ready for a command
// RESP  | response held until rsp_ready
module cmd_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              tx_start,
  output logic [7:0]        err_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state, state_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;
  logic               tx_start_q;
  logic [7:0]         err_cnt_q;

  logic               accept;
  logic               addr_err;
  logic               lock;
  logic               reject;
  logic [IDX_W-1:0]   idx;

  assign cmd_ready = (state == IDLE) && reset;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign tx_start  = tx_start_q;
  assign err_cnt   = err_cnt_q;

  assign accept   = cmd_valid && cmd_ready;
  assign addr_err = {1'b0, cmd_addr} >= DEPTH_V;
  assign idx      = cmd_addr[IDX_W-1:0];

`ifdef CMD_REGFILE_WLOCK_EN
  // Address 0 stays writable so the lock can always be released.
  assign lock = mem[0][0] && (cmd_addr != '0);
`else
  assign lock = 1'b0;
`endif

  assign reject = addr_err || (cmd_write && lock);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept && cmd_write && !reject) begin
      mem[idx] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tx_start_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (accept) begin
        // Read data is sampled before any same-edge write could land, which cannot happen anyway.
        rsp_data_q <= (!cmd_write && !reject) ? mem[idx] : '0;
        rsp_err_q  <= reject;
        tx_start_q <= !cmd_write;
        if (reject && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_regfile.sv
// Directed table-driven bench for cmd_regfile (default parameters 8/8/64).
// Covers handshake, errors, stall, saturation, reset mid-response and the optional write lock.
module tb_cmd_regfile;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       tx_start;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  cmd_regfile #(.DATA_W(8), .ADDR_W(8), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .tx_start(tx_start), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_data;
    logic       exp_err;
    logic       exp_tx;
    logic [7:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Caller is at posedge+1. Returns with the handshake done, again at posedge+1.
  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic re, output logic tx1,
                        output logic tx2, output logic hs_ok);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    hs_ok = cmd_ready;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rd = rsp_data; re = rsp_err; tx1 = tx_start;
    hs_ok = hs_ok && rsp_valid && !cmd_ready;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tx2 = tx_start;
    hs_ok = hs_ok && cmd_ready && !rsp_valid;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [7:0] rd;
    logic re, tx1, tx2, ok;
    do_cmd(v.w, v.a, v.d, rd, re, tx1, tx2, ok);
    chk({tag, ".handshake"}, ok, 1'b1);
    chk({tag, ".rsp_data"}, rd, v.exp_data);
    chk({tag, ".rsp_err"}, re, v.exp_err);
    chk({tag, ".tx_start"}, tx1, v.exp_tx);
    chk({tag, ".tx_after"}, tx2, 1'b0);
    chk({tag, ".err_cnt"}, err_cnt, v.exp_cnt);
  endtask

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic re, tx1, tx2, ok;
    int tx_cnt;

    vecs[0]  = '{1'b1, 8'd3,   8'hA5, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 1'b1, 8'd0};
    vecs[2]  = '{1'b0, 8'd64,  8'h00, 8'h00, 1'b1, 1'b1, 8'd1};
    vecs[3]  = '{1'b1, 8'd200, 8'h55, 8'h00, 1'b1, 1'b0, 8'd2};
    vecs[4]  = '{1'b1, 8'd63,  8'h3C, 8'h00, 1'b0, 1'b0, 8'd2};
    vecs[5]  = '{1'b0, 8'd63,  8'h00, 8'h3C, 1'b0, 1'b1, 8'd2};
    vecs[6]  = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 8'd0,   8'hC2, 8'h00, 1'b0, 1'b0, 8'd2};
    vecs[8]  = '{1'b0, 8'd0,   8'h00, 8'hC2, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 8'd3,   8'h5A, 8'h00, 1'b0, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 8'd3,   8'h00, 8'h5A, 1'b0, 1'b1, 8'd2};
    vecs[12] = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b1, 1'b1, 8'd3};

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.cmd_ready", cmd_ready, 1'b0);
    chk("reset.rsp_valid", rsp_valid, 1'b0);
    chk("reset.rsp_data", rsp_data, 8'h00);
    chk("reset.rsp_err", rsp_err, 1'b0);
    chk("reset.tx_start", tx_start, 1'b0);
    chk("reset.err_cnt", err_cnt, 8'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset.cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 13; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Stall: read 63 and hold rsp_ready low; a write presented meanwhile must be ignored.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'd63;
    @(posedge clk); #1;
    tx_cnt = tx_start ? 1 : 0;
    chk("stall.rsp_valid0", rsp_valid, 1'b1);
    cmd_write = 1'b1; cmd_wdata = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tx_start) tx_cnt++;
      chk($sformatf("stall%0d.rsp_valid", i), rsp_valid, 1'b1);
      chk($sformatf("stall%0d.rsp_data", i), rsp_data, 8'h3C);
      chk($sformatf("stall%0d.cmd_ready", i), cmd_ready, 1'b0);
    end
    chk("stall.tx_pulses", tx_cnt, 1);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    apply('{1'b0, 8'd63, 8'h00, 8'h3C, 1'b0, 1'b1, 8'd3}, "stall_readback");

    // Saturation of err_cnt, starting from 3.
    for (int i = 0; i < 260; i++) begin
      do_cmd(i[0], 8'd64 + 8'(i % 150), 8'h11, rd, re, tx1, tx2, ok);
      if (i == 251) chk("sat.reach255", err_cnt, 8'd255);
      if (i == 0) chk("sat.first", err_cnt, 8'd4);
    end
    chk("sat.hold255", err_cnt, 8'd255);

    // Reset while a response is pending.
    apply('{1'b1, 8'd7, 8'h77, 8'h00, 1'b0, 1'b0, 8'd255}, "pre_rst_write");
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_rst.in_resp", rsp_valid, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst.rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst.err_cnt", err_cnt, 8'd0);
    chk("mid_rst.rsp_data", rsp_data, 8'h00);
    chk("mid_rst.tx_start", tx_start, 1'b0);
    chk("mid_rst.cmd_ready", cmd_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst.ready_after", cmd_ready, 1'b1);
    apply('{1'b0, 8'd7, 8'h00, 8'h00, 1'b0, 1'b1, 8'd0}, "mid_rst.read7");
    apply('{1'b0, 8'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'd0}, "mid_rst.read3");

`ifdef CMD_REGFILE_WLOCK_EN
    apply('{1'b1, 8'd0, 8'h01, 8'h00, 1'b0, 1'b0, 8'd0}, "lock.set");
    apply('{1'b1, 8'd5, 8'h55, 8'h00, 1'b1, 1'b0, 8'd1}, "lock.blocked_wr");
    apply('{1'b0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b1, 8'd1}, "lock.read5");
    apply('{1'b0, 8'd0, 8'h00, 8'h01, 1'b0, 1'b1, 8'd1}, "lock.read0");
    apply('{1'b1, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1}, "lock.clear");
    apply('{1'b1, 8'd5, 8'h55, 8'h00, 1'b0, 1'b0, 8'd1}, "lock.open_wr");
    apply('{1'b0, 8'd5, 8'h00, 8'h55, 1'b0, 1'b1, 8'd1}, "lock.read5b");
`else
    apply('{1'b1, 8'd0, 8'h01, 8'h00, 1'b0, 1'b0, 8'd0}, "nolock.wr0");
    apply('{1'b1, 8'd5, 8'h55, 8'h00, 1'b0, 1'b0, 8'd0}, "nolock.wr5");
    apply('{1'b0, 8'd5, 8'h00, 8'h55, 1'b0, 1'b1, 8'd0}, "nolock.read5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_regfile.md
# cmd_regfile

Parametrised command-driven register file between the UART command parser and the UART transmitter. Accepts one read or write command per valid/ready handshake and returns a buffered response (data plus error flag) over a second valid/ready channel. Pulses a transmit trigger for every read response and counts rejected commands. Generalises the fixed 64x8 register file with configurable width and depth, backpressure, explicit error reporting, and an optional write lock.

## Interface
Parameters:
- DATA_W, 8, register and data width in bits
- ADDR_W, 8, command address width; DEPTH must be ≤ 2^ADDR_W
- DEPTH, 64, number of implemented registers, addresses 0..DEPTH-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  command rejected
- tx_start  out  1  one-cycle pulse when a read response first becomes valid
- err_cnt  out  8  saturating count of rejected commands

## Operation
- FSM states: IDLE, RESP. Reset state: IDLE.
- cmd_ready = (state == IDLE) && reset. It is combinational from state and is 0 while reset is low.
- IDLE: on cmd_valid && cmd_ready, execute the command and latch the response. Go to RESP.
- RESP: hold rsp_valid, rsp_data and rsp_err stable until rsp_valid && rsp_ready. Then go to IDLE.
- Address error: cmd_addr ≥ DEPTH.
  - No storage change.
  - rsp_err = 1, rsp_data = 0.
- Write (no error): mem[cmd_addr] ← cmd_wdata. rsp_data = 0, rsp_err = 0.
- Read (no error): rsp_data = mem[cmd_addr], rsp_err = 0.
  - The value comes from storage at the acceptance edge.
- Every rejected command increments err_cnt. It saturates at 255 and never wraps.
- tx_start is asserted for read responses only, including erroneous reads, which send 0.
- Reset values:
  - all mem = 0
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0
  - tx_start = 0, err_cnt = 0
  - state = IDLE
- Reset asserted mid-RESP: the pending response is discarded. No handshake is needed.

## Timing
- Command accepted at edge N: storage update and response registers are loaded at edge N.
- rsp_valid = 1 in cycle N+1. tx_start = 1 in cycle N+1 only, regardless of rsp_ready.
- rsp_ready high in cycle N+1 completes the handshake at edge N+1. cmd_ready = 1 in cycle N+2.
- Maximum throughput is one command per 2 cycles. rsp_ready held low stalls indefinitely and keeps cmd_ready = 0.
- A read immediately after a write to the same address returns the new value.
  - This needs no bypass: the commands are at least 2 cycles apart.
- Inputs are ignored while cmd_ready = 0.

## Configuration
- Macro: CMD_REGFILE_WLOCK_EN.
- Defined:
  - mem[0] bit 0 is a write lock.
  - While it is 1, writes to addresses 1..DEPTH-1 are rejected: rsp_err = 1, err_cnt increments, storage is unchanged.
  - Address 0 stays writable, so the lock can be cleared. Reads are never blocked.
- Undefined: address 0 is ordinary storage, and only address range errors exist.

## Test plan
- Reset, then write 0xA5 to address 3, then read address 3 → write response rsp_err = 0, rsp_data = 0; read response rsp_data = 0xA5, one tx_start pulse in the cycle rsp_valid rises.
- Read address 64 (DEPTH = 64) → rsp_err = 1, rsp_data = 0, tx_start pulses, err_cnt = 1. Write address 200 → rsp_err = 1, no tx_start, err_cnt = 2.
- Hold rsp_ready = 0 for 10 cycles after a read → rsp_valid and rsp_data stable, cmd_ready = 0 throughout, tx_start high exactly 1 cycle.
- Issue 260 out-of-range commands → err_cnt reaches 255 and stays 255.
- Assert reset while in RESP → next cycle rsp_valid = 0, err_cnt = 0, a read of a previously written address returns 0.
- With CMD_REGFILE_WLOCK_EN: write 0x01 to address 0, then write 0x55 to address 5 → rsp_err = 1, address 5 still reads 0. Write 0x00 to address 0, then write 0x55 to address 5 → accepted, and address 5 reads 0x55.
